mem_interface_unit: RTL and testbench

- Responder side of the instruction-unit load/store handshake.
- Accepts one load or store request at a time and runs it as byte transactions on the main-memory bus (req/resp handshake).
- A load returns one byte. A store writes a 16-bit ALU result as two bytes, low byte first.
- Completion is signalled with a one-cycle mem_done pulse.
- Sits between the instruction unit and main memory in the TinyALU CPU.

---
 rtl/tinyalu_pkg.sv | 16 +
 rtl/mem_interface_unit_if.sv | 34 +++
 rtl/miu_watchdog.sv | 32 +++
 rtl/mem_interface_unit.sv | 133 +++++++++++++
 tb/tb_mem_interface_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared types and constants for the TinyALU memory interface unit
package tinyalu_pkg;

    localparam int MIU_ADDR_W = 14;
    localparam int MIU_DATA_W = 8;
    localparam logic [7:0] MIU_TIMEOUT_VAL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST_LO,
        ST_HI,
        DONE
    } miu_state_t;

endpackage

// File: rtl/mem_interface_unit_if.sv
// mem_interface_unit_if: IU request/completion signals plus the byte-wide main-memory bus
interface mem_interface_unit_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);

    logic                  load;
    logic                  store;
    logic [ADDR_W-1:0]     addr;
    logic [2*DATA_W-1:0]   result;
    logic [DATA_W-1:0]     data;
    logic                  mem_done;
    logic                  busy;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_resp;
    logic                  mem_err;

    // The unit itself: consumes IU requests and memory responses
    modport slave (
        input  load, store, addr, result, mem_rdata, mem_resp,
        output data, mem_done, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_err
    );

    // The surrounding IU and memory
    modport master (
        output load, store, addr, result, mem_rdata, mem_resp,
        input  data, mem_done, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_err
    );

endinterface

// File: rtl/miu_watchdog.sv
// miu_watchdog: wait-cycle counter that flags when a memory request has waited LIMIT cycles
module miu_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over count so each request state starts from zero
    always_comb begin
        cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_interface_unit.sv
// mem_interface_unit: runs IU loads/stores as byte transactions on main memory; MIU_TIMEOUT_EN adds a response timeout
module mem_interface_unit
    import tinyalu_pkg::*;
#(
    parameter int ADDR_W = MIU_ADDR_W,
    parameter int DATA_W = MIU_DATA_W
`ifdef MIU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_interface_unit_if.slave bus
);

    miu_state_t            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_err_q, mem_err_d;
    logic                  mem_done_q;
    logic                  timed_out;

`ifdef MIU_TIMEOUT_EN
    logic wd_active;

    assign wd_active = state_q inside {LD, ST_LO, ST_HI};

    miu_watchdog #(
        .LIMIT(TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (!wd_active || bus.mem_resp),
        .en_i     (wd_active && !bus.mem_resp),
        .expired_o(timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    // Next state, request latches, load data and timeout flag
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        result_d  = result_q;
        data_d    = data_q;
        mem_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    addr_d  = bus.addr;
                    state_d = LD;
                end else if (bus.store) begin
                    addr_d   = bus.addr;
                    result_d = bus.result;
                    state_d  = ST_LO;
                end
            end
            LD: begin
                if (bus.mem_resp) begin
                    data_d  = bus.mem_rdata;
                    state_d = DONE;
                end else if (timed_out) begin
                    data_d    = DATA_W'(MIU_TIMEOUT_VAL);
                    mem_err_d = 1'b1;
                    state_d   = DONE;
                end
            end
            ST_LO, ST_HI: begin
                if (bus.mem_resp) begin
                    state_d = (state_q == ST_LO) ? ST_HI : DONE;
                end else if (timed_out) begin
                    mem_err_d = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are derived from the state being entered so they are registered yet aligned with it
    always_comb begin
        mem_req_d   = state_d inside {LD, ST_LO, ST_HI};
        mem_we_d    = state_d inside {ST_LO, ST_HI};
        mem_addr_d  = (state_d == ST_HI) ? addr_d + ADDR_W'(1) : mem_req_d ? addr_d : mem_addr_q;
        mem_wdata_d = (state_d == ST_LO) ? result_d[DATA_W-1:0]
                    : (state_d == ST_HI) ? result_d[2*DATA_W-1:DATA_W]
                    : mem_wdata_q;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            result_q    <= '0;
            data_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            result_q    <= result_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_err_q   <= mem_err_d;
            mem_done_q  <= (state_d == DONE);
        end
    end

    assign bus.data      = data_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// tb_mem_interface_unit: self-checking bench for mem_interface_unit; timeout cases run when MIU_TIMEOUT_EN is defined
module tb_mem_interface_unit;

    typedef struct {
        logic        ld;
        logic        st;
        logic [13:0] a;
        logic [15:0] r;
        int          l1;
        int          l2;
        logic [7:0]  exp_data;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        we;
        logic [13:0] a;
        logic [7:0]  d;
    } xact_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_interface_unit_if #(.ADDR_W(14), .DATA_W(8)) bus ();

    mem_interface_unit dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] env_mem [16384];
    logic [7:0] ref_mem [16384];
    logic [7:0] ref_data;
    xact_t      log_q[$];
    int         lat1 = 0;
    int         lat2 = 0;
    int         stray_req = 0;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 6));
    endfunction

    // Memory environment: acknowledges a request after a programmable number of wait cycles
    initial begin
        int    wcnt = 0;
        int    beat = 0;
        int    stray_seen = 0;
        xact_t x;
        for (int i = 0; i < 16384; i++) env_mem[i] = init_byte(i);
        env_mem[14'h0010] = 8'h5A;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 8'($urandom);
            if (stray_req != stray_seen) begin
                stray_seen   = stray_req;
                bus.mem_resp = 1'b1;
            end else if (bus.mem_req !== 1'b1) begin
                wcnt = 0;
                beat = 0;
            end else if (wcnt >= (beat == 0 ? lat1 : lat2)) begin
                x.we = bus.mem_we;
                x.a  = bus.mem_addr;
                x.d  = bus.mem_wdata;
                log_q.push_back(x);
                if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata = env_mem[bus.mem_addr];
                bus.mem_resp = 1'b1;
                beat++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits for mem_done; n counts negedges from the sampling edge, reqs counts cycles with mem_req high
    task automatic wait_done(input bit scramble, output int n, output int reqs);
        n    = 0;
        reqs = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.mem_req === 1'b1) reqs++;
            if (scramble) begin
                bus.addr   = 14'($urandom);
                bus.result = 16'($urandom);
            end
        end while (bus.mem_done !== 1'b1 && n < 1000);
        chk("done_seen", bus.mem_done, 1);
    endtask

    // Reference: a load reads one byte at addr; a store writes low byte at addr, high byte at addr+1 mod 2^14
    task automatic check_op(input string tag, input logic ld, input logic [13:0] a, input logic [15:0] r);
        logic [13:0] a2;
        a2 = 14'((32'(a) + 1) % 16384);
        if (ld) begin
            chk({tag, "_nx"}, log_q.size(), 1);
            if (log_q.size() == 1) begin
                chk({tag, "_rd_we"}, log_q[0].we, 0);
                chk({tag, "_rd_a"}, log_q[0].a, a);
            end
            ref_data = ref_mem[a];
        end else begin
            chk({tag, "_nx"}, log_q.size(), 2);
            if (log_q.size() == 2) begin
                chk({tag, "_lo"}, {log_q[0].we, log_q[0].a, log_q[0].d}, {1'b1, a, r[7:0]});
                chk({tag, "_hi"}, {log_q[1].we, log_q[1].a, log_q[1].d}, {1'b1, a2, r[15:8]});
            end
            ref_mem[a]  = r[7:0];
            ref_mem[a2] = r[15:8];
        end
        chk({tag, "_data"}, bus.data, ref_data);
    endtask

    task automatic run_op(input string tag, input logic ld, input logic st, input logic [13:0] a,
                          input logic [15:0] r, input int l1, input int l2, output int lat);
        int reqs;
        @(negedge clk);
        log_q.delete();
        lat1       = l1;
        lat2       = l2;
        bus.load   = ld;
        bus.store  = st;
        bus.addr   = a;
        bus.result = r;
        wait_done(1'b1, lat, reqs);
        chk({tag, "_err"}, bus.mem_err, 0);
        check_op(tag, ld, a, r);
        bus.load  = 1'b0;
        bus.store = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, bus.mem_done, 0);
        chk({tag, "_hold"}, bus.data, ref_data);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vec_t        tbl[6];
        int          lat;
        int          n;
        int          reqs;
        logic        isld;
        logic [13:0] ra;
        logic [15:0] rr;
        int          rl1;
        int          rl2;
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_byte(i);
        ref_mem[14'h0010] = 8'h5A;
        ref_data   = 8'h00;
        bus.load   = 1'b0;
        bus.store  = 1'b0;
        bus.addr   = '0;
        bus.result = '0;
        tbl[0] = '{1'b1, 1'b0, 14'h0010, 16'h0000, 3, 0, 8'h5A, 5};
        tbl[1] = '{1'b0, 1'b1, 14'h0012, 16'hBEEF, 0, 0, 8'h5A, 3};
        tbl[2] = '{1'b0, 1'b1, 14'h3FFF, 16'h1234, 1, 2, 8'h5A, 6};
        tbl[3] = '{1'b1, 1'b0, 14'h3FFF, 16'h0000, 0, 0, 8'h34, 2};
        tbl[4] = '{1'b1, 1'b0, 14'h0000, 16'h0000, 2, 0, 8'h12, 4};
        tbl[5] = '{1'b1, 1'b0, 14'h0013, 16'h0000, 1, 0, 8'hBE, 3};

        repeat (3) @(negedge clk);
        chk("rst_data", bus.data, 0);
        chk("rst_done", bus.mem_done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_err", bus.mem_err, 0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            run_op($sformatf("vec%0d", i), tbl[i].ld, tbl[i].st, tbl[i].a, tbl[i].r, tbl[i].l1, tbl[i].l2, lat);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_tbl_data", i), bus.data, tbl[i].exp_data);
        end

        for (int k = 0; k < 40; k++) begin
            isld = 1'($urandom_range(0, 1));
            ra   = (k % 8 == 7) ? 14'h3FFF : 14'($urandom_range(0, 63));
            rr   = 16'($urandom);
            rl1  = $urandom_range(0, 3);
            rl2  = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d", k), isld, !isld, ra, rr, rl1, rl2, lat);
            chk($sformatf("rnd%0d_lat", k), lat, isld ? 2 + rl1 : 3 + rl1 + rl2);
        end

        // Load and store together: load first, the still-held store follows
        @(negedge clk);
        log_q.delete();
        lat1       = 1;
        lat2       = 0;
        bus.load   = 1'b1;
        bus.store  = 1'b1;
        bus.addr   = 14'h0020;
        bus.result = 16'hCAFE;
        wait_done(1'b0, n, reqs);
        chk("both_ld_lat", n, 3);
        check_op("both_ld", 1'b1, 14'h0020, 16'hCAFE);
        log_q.delete();
        bus.load = 1'b0;
        wait_done(1'b0, n, reqs);
        chk("both_st_lat", n, 5);
        check_op("both_st", 1'b0, 14'h0020, 16'hCAFE);
        bus.store = 1'b0;
        @(negedge clk);
        chk("both_pulse", bus.mem_done, 0);

        // Reset while waiting in the high-byte write
        @(negedge clk);
        log_q.delete();
        lat1       = 0;
        lat2       = 1000;
        bus.store  = 1'b1;
        bus.addr   = 14'h0100;
        bus.result = 16'h55AA;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_req === 1'b1 && bus.mem_addr === 14'h0101) && n < 50);
        chk("rst_sthi_addr", bus.mem_addr, 14'h0101);
        chk("rst_sthi_wdata", bus.mem_wdata, 8'h55);
        ref_mem[14'h0100] = 8'hAA;
        repeat (2) @(negedge clk);
        reset_n   = 1'b0;
        bus.store = 1'b0;
        @(negedge clk);
        chk("rstmid_req", bus.mem_req, 0);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_done", bus.mem_done, 0);
        chk("rstmid_data", bus.data, 0);
        reset_n  = 1'b1;
        ref_data = 8'h00;
        stray_req++;
        repeat (4) begin
            @(negedge clk);
            chk("stray_done", bus.mem_done, 0);
            chk("stray_busy", bus.busy, 0);
        end
        chk("stray_data", bus.data, 0);

`ifdef MIU_TIMEOUT_EN
        // Memory never answers a load
        @(negedge clk);
        log_q.delete();
        lat1     = 100000;
        bus.load = 1'b1;
        bus.addr = 14'h0055;
        wait_done(1'b0, n, reqs);
        chk("to_ld_reqs", reqs, 255);
        chk("to_ld_err", bus.mem_err, 1);
        chk("to_ld_data", bus.data, 8'hFF);
        chk("to_ld_nx", log_q.size(), 0);
        bus.load = 1'b0;
        @(negedge clk);
        chk("to_ld_err_pulse", bus.mem_err, 0);
        chk("to_ld_done_pulse", bus.mem_done, 0);
        // Memory never answers the low byte of a store: high byte is skipped
        @(negedge clk);
        log_q.delete();
        bus.store  = 1'b1;
        bus.addr   = 14'h0060;
        bus.result = 16'h9876;
        wait_done(1'b0, n, reqs);
        chk("to_st_reqs", reqs, 255);
        chk("to_st_err", bus.mem_err, 1);
        chk("to_st_data", bus.data, 8'hFF);
        chk("to_st_nx", log_q.size(), 0);
        bus.store = 1'b0;
        @(negedge clk);
        chk("to_st_busy", bus.busy, 0);
        chk("to_st_req", bus.mem_req, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
